mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Produces the per-requester completion strobes `i_valid` and `d_valid`. The hazard unit consumes these as its fetch-valid and mem-valid inputs.
- Handles in-flight fetches cancelled by a branch or jump (drain without delivery), plus a bus watchdog timeout.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- D_PRIORITY, 1, 1 = D always wins a tie; 0 = round-robin on tie
- TIMEOUT, 255, bus cycles without `bus_ack` before forced completion; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- i_req  in  1  fetch request; held until `i_valid`
- i_addr  in  ADDR_W  fetch address; stable while `i_req` is high
- i_kill  in  1  discard the granted or in-flight fetch (branch/jump flush)
- i_valid  out  1  fetch complete, or no fetch pending
- i_rdata  out  DATA_W  fetch data, qualified by `i_valid && i_req`
- d_req  in  1  data request; held until `d_valid`
- d_we  in  1  1 = store
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_valid  out  1  data access complete, or no data access pending
- d_rdata  out  DATA_W  load data
- bus_req  out  1  memory request
- bus_we  out  1  memory write
- bus_be  out  DATA_W/8  byte enables
- bus_addr  out  ADDR_W  memory address
- bus_wdata  out  DATA_W  memory write data
- bus_ack  in  1  single-cycle completion from memory
- bus_rdata  in  DATA_W  read data, valid with `bus_ack`
- bus_timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:

Clock and reset:
- One clock, `clk`.
- Reset is asynchronous and active-low (`rst_n`).
- On reset: state = IDLE; `bus_req`, `bus_we`, `bus_timeout` = 0; `bus_addr`, `bus_wdata`, `bus_be` = 0; round-robin pointer favours D; watchdog counter = 0.
- Reset mid-transaction abandons the transaction. Memory must tolerate `bus_req` dropping without an ack.

States:
- IDLE, I_BUSY, D_BUSY, I_DRAIN.

Grant (evaluated in IDLE, and in any BUSY/DRAIN state on its completion cycle):
- Candidates are `d_req`, and `i_req && !i_kill`.
- Tie resolves per D_PRIORITY. In round-robin mode the pointer flips after every grant.
- On grant, the `bus_*` registers load the winner's address, data, byte enables and write flag. `bus_req` = 1 from the next cycle.
- I grants force `bus_we` = 0 and `bus_be` = all ones.

Completion and transitions:
- In x_BUSY, a cycle with `bus_ack` = 1 completes the access.
- The winner's valid is asserted combinationally in that cycle; `x_rdata` = `bus_rdata`.
- The next state is the new grant if one exists (`bus_req` stays high with new fields). Otherwise go to IDLE with `bus_req` = 0.
- Memory treats the cycle after an ack with `bus_req` still high as a new request.

Valid outputs:
- `i_valid` = (`!i_req` and state ≠ I_BUSY/I_DRAIN) or (I_BUSY and `bus_ack`) or (I_BUSY and timeout).
- `d_valid` is the same with D_BUSY, except that D has no drain state.
- With the request low, valid is held high so the hazard unit does not stall.

Kill handling:
- `i_kill` in I_BUSY without `bus_ack`: go to I_DRAIN.
- `i_kill` in I_BUSY together with `bus_ack`: the completion is suppressed (`i_valid` = `!i_req`), then normal grant.
- I_DRAIN: wait for `bus_ack` (or timeout); never assert `i_valid`; the data is dropped. On ack, grant as normal; the redirected fetch may win.
- `i_kill` outside I_BUSY/I_DRAIN has no effect.

Watchdog:
- The counter clears on every grant and increments each cycle in BUSY/DRAIN.
- When TIMEOUT ≠ 0 and count = TIMEOUT-1 without an ack: treat as a completion with rdata = 0, and pulse `bus_timeout` for 1 cycle.
- An ack arriving in the expiry cycle wins; no pulse is generated.

Other rules:
- Stores complete with `d_rdata` = `bus_rdata`; software ignores it.
- Minimum latency: request seen in IDLE at cycle 0, `bus_req` at cycle 1, valid at cycle 1 if memory acks combinationally.

Decomposition:
- Package `mem_arb_pkg`: state enum (IDLE, I_BUSY, D_BUSY, I_DRAIN) and the grant-select encoding.
- One sub-module, `bus_watchdog`: a clearable counter with parameter TIMEOUT, inputs `clr` and `en`, output `expire`.
- Grant logic and FSM stay inline.

Test Plan:
1. Solo fetch: `i_req`=1, `i_addr`=0x100, memory acks 2 cycles after `bus_req` with 0xDEADBEEF -> `bus_addr`=0x100, `bus_we`=0; `i_valid` high only in the ack cycle; `i_rdata`=0xDEADBEEF; `d_valid` high throughout.
2. Simultaneous requests, D_PRIORITY=1: I at 0x200, D store of 0x55 to 0x3000 with `d_be`=0x1 -> D served first (`bus_we`=1, `bus_be`=0x1). The I grant follows directly in the D ack cycle, with `bus_req` continuously high. With D_PRIORITY=0 and both held, grants alternate I, D, I.
3. Kill in flight: I granted at 0x400, `i_kill` pulsed 1 cycle before ack -> I_DRAIN; `i_valid` stays 0 through the ack; next request at 0x800 granted the cycle after ack.
4. Kill coincident with ack -> no `i_valid` pulse; state returns to IDLE.
5. Watchdog, TIMEOUT=4: D load with no ack -> `bus_timeout` pulses on the 4th BUSY cycle; `d_valid`=1 with `d_rdata`=0; `bus_req` drops.
6. Async reset asserted mid D_BUSY -> `bus_req`=0 immediately; state IDLE; both valids high once requests drop.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: FSM states, grant selection and
// the tie-break helper used by the grant logic.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BUSY  = 2'd1,
        D_BUSY  = 2'd2,
        I_DRAIN = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_sel_e;

    // D wins when it is the only candidate, when D has fixed priority, or
    // when the round-robin pointer currently favours D.
    function automatic gnt_sel_e pick_grant(input logic i_cand,
                                            input logic d_cand,
                                            input logic d_prio,
                                            input logic rr_d);
        gnt_sel_e sel;
        sel = GNT_NONE;
        if (d_cand && (!i_cand || d_prio || rr_d))
            sel = GNT_D;
        else if (i_cand)
            sel = GNT_I;
        return sel;
    endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Bus watchdog: counts cycles spent waiting for an ack and flags expiry on
// the TIMEOUT-th waiting cycle. TIMEOUT = 0 disables expiry entirely.
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Clear on every grant; otherwise count while a transaction is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + CW'(1);
    end

    assign expire = (TIMEOUT != 0) && en && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch (I) and
// load/store (D). Produces per-requester completion strobes, drains killed
// fetches without delivering them, and forces completion on bus timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int D_PRIORITY = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_kill,
    output logic                  i_valid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_valid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  bus_timeout
);

    arb_state_e state, state_nxt;
    gnt_sel_e   gnt;
    logic       rr_d;
    logic       in_txn, expire, done, gnt_window;
    logic       i_cand, d_cand;

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (gnt != GNT_NONE),
        .en    (in_txn),
        .expire(expire)
    );

    // Grant selection. The requester completing this cycle still has its
    // request high (it drops it after seeing valid), so it is excluded from
    // the candidates to avoid re-serving the same access.
    always_comb begin
        in_txn     = (state != IDLE);
        done       = in_txn && (bus_ack || expire);
        gnt_window = !in_txn || done;
        i_cand     = i_req && !i_kill && !((state == I_BUSY) && done);
        d_cand     = d_req && !((state == D_BUSY) && done);
        gnt        = GNT_NONE;
        if (gnt_window)
            gnt = pick_grant(i_cand, d_cand, D_PRIORITY != 0, rr_d);
    end

    // Next state and completion strobes. An idle requester reads as valid so
    // the hazard unit never stalls on it.
    always_comb begin
        state_nxt = state;
        i_valid   = !i_req;
        d_valid   = !d_req;
        case (state)
            I_BUSY: begin
                i_valid = done && (!i_kill || !i_req);
                if (!done && i_kill)
                    state_nxt = I_DRAIN;
            end
            I_DRAIN: i_valid = 1'b0;
            D_BUSY:  d_valid = done;
            default: ;
        endcase
        if (gnt_window) begin
            case (gnt)
                GNT_I:   state_nxt = I_BUSY;
                GNT_D:   state_nxt = D_BUSY;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A watchdog expiry returns zero data; a real ack always wins.
    assign i_rdata     = bus_ack ? bus_rdata : '0;
    assign d_rdata     = bus_ack ? bus_rdata : '0;
    assign bus_timeout = in_txn && expire && !bus_ack;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Bus request registers load the winner's fields at grant time; the
    // round-robin pointer toggles on every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rr_d      <= 1'b1;
        end else if (gnt_window) begin
            bus_req <= (gnt != GNT_NONE);
            if (gnt == GNT_I) begin
                bus_we    <= 1'b0;
                bus_be    <= '1;
                bus_addr  <= i_addr;
                bus_wdata <= '0;
            end else if (gnt == GNT_D) begin
                bus_we    <= d_we;
                bus_be    <= d_be;
                bus_addr  <= d_addr;
                bus_wdata <= d_wdata;
            end
            if ((D_PRIORITY == 0) && (gnt != GNT_NONE))
                rr_d <= !rr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vector table, directed corner sequences
// (kill/drain, watchdog, async reset, round-robin) and a randomized run
// checked against a transaction-level owner/age reference model.
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_req, i_kill, d_req, d_we, bus_ack;
    logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
    logic [3:0]  d_be;
    logic        i_valid, d_valid, bus_req, bus_we, bus_timeout;
    logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIORITY(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_timeout(bus_timeout)
    );

    // Round-robin instance; memory acks combinationally every request cycle.
    logic        r_i_req, r_d_req, r_i_valid, r_d_valid, r_bus_req, r_bus_we, r_bus_timeout;
    logic [31:0] r_i_rdata, r_d_rdata, r_bus_addr, r_bus_wdata;
    logic [3:0]  r_bus_be;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIORITY(0), .TIMEOUT(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .i_req(r_i_req), .i_addr(32'h10), .i_kill(1'b0), .i_valid(r_i_valid), .i_rdata(r_i_rdata),
        .d_req(r_d_req), .d_we(1'b0), .d_be(4'hF), .d_addr(32'h20), .d_wdata(32'h0),
        .d_valid(r_d_valid), .d_rdata(r_d_rdata),
        .bus_req(r_bus_req), .bus_we(r_bus_we), .bus_be(r_bus_be), .bus_addr(r_bus_addr),
        .bus_wdata(r_bus_wdata), .bus_ack(r_bus_req), .bus_rdata(32'h0), .bus_timeout(r_bus_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    typedef struct {
        logic i_req; logic [31:0] i_addr; logic i_kill;
        logic d_req; logic d_we; logic [3:0] d_be; logic [31:0] d_addr; logic [31:0] d_wdata;
        logic ack; logic [31:0] rdata;
        logic e_breq; logic e_bwe; logic [3:0] e_bbe; logic [31:0] e_baddr;
        logic e_iv; logic e_dv; logic [31:0] e_rd;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    // reference model state for the random run
    int          own;       // 0 none, 1 fetch, 2 data, 3 killed fetch
    int          age;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_be;
    logic        e_iv, e_dv, iv_s, dv_s, in_t, exp_x, done, ic, dc;

    initial begin
        i_req = 0; i_addr = 0; i_kill = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        bus_ack = 0; bus_rdata = 0; r_i_req = 0; r_d_req = 0;

        // cycle vectors: solo fetch, D-priority tie, kill with ack, min-latency load
        tbl[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,    1'b0, 1'b1, 32'h0};
        tbl[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b0, 32'h0,        1'b1, 1'b0, 4'hF, 32'h100,  1'b0, 1'b1, 32'h0};
        tbl[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b0, 32'h0,        1'b1, 1'b0, 4'hF, 32'h100,  1'b0, 1'b1, 32'h0};
        tbl[3]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 4'hF, 32'h100,  1'b1, 1'b1, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 32'h100,  1'b1, 1'b1, 32'h0};
        tbl[5]  = '{1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 4'h1, 32'h3000, 32'h55, 1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 32'h100,  1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 4'h1, 32'h3000, 32'h55, 1'b1, 32'h0,        1'b1, 1'b1, 4'h1, 32'h3000, 1'b0, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b1, 32'h12345678, 1'b1, 1'b0, 4'hF, 32'h200,  1'b1, 1'b1, 32'h12345678};
        tbl[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 32'h200,  1'b1, 1'b1, 32'h0};
        tbl[9]  = '{1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 32'h200,  1'b0, 1'b1, 32'h0};
        tbl[10] = '{1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b1, 32'hAAAA5555, 1'b1, 1'b0, 4'hF, 32'h500,  1'b0, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 32'h500,  1'b1, 1'b1, 32'h0};
        tbl[12] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 4'hF, 32'h40,   32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 32'h500,  1'b1, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 4'hF, 32'h40,   32'h0,  1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 4'hF, 32'h40,   1'b1, 1'b1, 32'hCAFEF00D};
        tbl[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 4'hF, 32'h40,   1'b1, 1'b1, 32'h0};

        // reset state
        #1;
        check("rst bus_req", bus_req, 0);
        check("rst bus_we", bus_we, 0);
        check("rst bus_be", bus_be, 0);
        check("rst bus_addr", bus_addr, 0);
        check("rst bus_wdata", bus_wdata, 0);
        check("rst bus_timeout", bus_timeout, 0);
        check("rst i_valid", i_valid, 1);
        check("rst d_valid", d_valid, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            i_req = tbl[k].i_req; i_addr = tbl[k].i_addr; i_kill = tbl[k].i_kill;
            d_req = tbl[k].d_req; d_we = tbl[k].d_we; d_be = tbl[k].d_be;
            d_addr = tbl[k].d_addr; d_wdata = tbl[k].d_wdata;
            bus_ack = tbl[k].ack; bus_rdata = tbl[k].rdata;
            #1;
            check($sformatf("vec%0d bus_req", k), bus_req, tbl[k].e_breq);
            check($sformatf("vec%0d bus_we", k), bus_we, tbl[k].e_bwe);
            check($sformatf("vec%0d bus_be", k), bus_be, tbl[k].e_bbe);
            check($sformatf("vec%0d bus_addr", k), bus_addr, tbl[k].e_baddr);
            check($sformatf("vec%0d i_valid", k), i_valid, tbl[k].e_iv);
            check($sformatf("vec%0d d_valid", k), d_valid, tbl[k].e_dv);
            check($sformatf("vec%0d bus_timeout", k), bus_timeout, 0);
            if (tbl[k].i_req && tbl[k].e_iv) check($sformatf("vec%0d i_rdata", k), i_rdata, tbl[k].e_rd);
            if (tbl[k].d_req && tbl[k].e_dv) check($sformatf("vec%0d d_rdata", k), d_rdata, tbl[k].e_rd);
        end

        // kill while in flight: drain, then the redirected fetch
        @(negedge clk); i_req = 1; i_addr = 32'h400; i_kill = 0; bus_ack = 0; bus_rdata = 0;
        @(negedge clk); #1;
        check("kill busy addr", bus_addr, 32'h400);
        check("kill busy i_valid", i_valid, 0);
        @(negedge clk); i_kill = 1; i_addr = 32'h800; #1;
        check("kill pulse i_valid", i_valid, 0);
        @(negedge clk); i_kill = 0; bus_ack = 1; bus_rdata = 32'h1111; #1;
        check("drain ack i_valid", i_valid, 0);
        check("drain ack bus_req", bus_req, 1);
        @(negedge clk); bus_ack = 0; #1;
        check("redirect bus_req", bus_req, 1);
        check("redirect bus_addr", bus_addr, 32'h800);
        check("redirect i_valid", i_valid, 0);
        @(negedge clk); bus_ack = 1; bus_rdata = 32'h2222; #1;
        check("redirect i_valid ack", i_valid, 1);
        check("redirect i_rdata", i_rdata, 32'h2222);
        @(negedge clk); i_req = 0; bus_ack = 0; #1;
        check("redirect idle bus_req", bus_req, 0);

        // watchdog expiry on the 4th waiting cycle
        @(negedge clk); d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h60; bus_rdata = 32'hBAD0BAD0;
        for (int k = 1; k < TMO; k++) begin
            @(negedge clk); #1;
            check($sformatf("wdog wait%0d timeout", k), bus_timeout, 0);
            check($sformatf("wdog wait%0d d_valid", k), d_valid, 0);
        end
        @(negedge clk); #1;
        check("wdog expire timeout", bus_timeout, 1);
        check("wdog expire d_valid", d_valid, 1);
        check("wdog expire d_rdata", d_rdata, 0);
        @(negedge clk); d_req = 0; #1;
        check("wdog after bus_req", bus_req, 0);
        check("wdog after timeout", bus_timeout, 0);

        // ack in the expiry cycle beats the watchdog
        @(negedge clk); d_req = 1; d_addr = 32'h64;
        for (int k = 1; k < TMO; k++) @(negedge clk);
        @(negedge clk); bus_ack = 1; bus_rdata = 32'h77; #1;
        check("wdog race timeout", bus_timeout, 0);
        check("wdog race d_valid", d_valid, 1);
        check("wdog race d_rdata", d_rdata, 32'h77);
        @(negedge clk); d_req = 0; bus_ack = 0;

        // asynchronous reset in the middle of a data access
        @(negedge clk); d_req = 1; d_addr = 32'h70;
        @(negedge clk); #1;
        check("arst pre bus_req", bus_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst bus_req", bus_req, 0);
        check("arst bus_addr", bus_addr, 0);
        check("arst d_valid pending", d_valid, 0);
        d_req = 0;
        #1;
        check("arst i_valid", i_valid, 1);
        check("arst d_valid", d_valid, 1);
        @(negedge clk); rst_n = 1'b1;

        // round-robin: first tie goes to D, then strict alternation
        @(negedge clk); r_i_req = 1; r_d_req = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            check($sformatf("rr grant%0d bus_req", k), r_bus_req, 1);
            check($sformatf("rr grant%0d addr", k), r_bus_addr, (k % 2 == 1) ? 32'h20 : 32'h10);
            if (k == 5) begin r_i_req = 0; r_d_req = 0; end
        end
        @(negedge clk); #1;
        check("rr idle bus_req", r_bus_req, 0);
        r_i_req = 1; r_d_req = 1;   // five grants toggled the pointer to favour I
        @(negedge clk); #1;
        check("rr tie after odd grants", r_bus_addr, 32'h10);
        r_i_req = 0; r_d_req = 0;

        // randomized traffic against the owner/age reference model
        @(negedge clk);
        @(negedge clk);
        own = 0; age = 0; iv_s = 0; dv_s = 0;
        m_addr = 0; m_wdata = 0; m_we = 0; m_be = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            i_kill = 0;
            if (i_req && iv_s) begin
                i_req = ($urandom % 2) == 0; i_addr = rnd_addr();
            end else if (!i_req) begin
                if ($urandom % 100 < 30) begin i_req = 1; i_addr = rnd_addr(); end
            end else if ($urandom % 100 < 8) begin
                i_kill = 1; i_addr = rnd_addr();
            end
            if ((d_req && dv_s) || (!d_req && ($urandom % 100 < 30))) begin
                d_req = d_req ? (($urandom % 2) == 0) : 1'b1;
                d_we = $urandom % 2;
                d_be = d_we ? 4'($urandom % 15 + 1) : 4'hF;
                d_addr = rnd_addr(); d_wdata = $urandom;
            end
            bus_ack = bus_req && ($urandom % 100 < 40);
            bus_rdata = bus_ack ? mem_f(bus_addr) : $urandom;
            #1;
            in_t  = (own != 0);
            exp_x = in_t && (age == TMO - 1);
            done  = in_t && (bus_ack || exp_x);
            e_iv  = (own == 1) ? (done && (!i_kill || !i_req)) : (own == 3) ? 1'b0 : !i_req;
            e_dv  = (own == 2) ? done : !d_req;
            check("rnd bus_req", bus_req, in_t);
            check("rnd i_valid", i_valid, e_iv);
            check("rnd d_valid", d_valid, e_dv);
            check("rnd bus_timeout", bus_timeout, exp_x && !bus_ack);
            if (in_t) begin
                check("rnd bus_addr", bus_addr, m_addr);
                check("rnd bus_we", bus_we, m_we);
                check("rnd bus_be", bus_be, m_be);
                if (own == 2 && m_we) check("rnd bus_wdata", bus_wdata, m_wdata);
            end
            if (own == 1 && done && !i_kill) check("rnd i_rdata", i_rdata, bus_ack ? mem_f(m_addr) : 32'h0);
            if (own == 2 && done) check("rnd d_rdata", d_rdata, bus_ack ? mem_f(m_addr) : 32'h0);
            iv_s = e_iv; dv_s = e_dv;
            // advance the model: the requester served this cycle is not re-served
            ic = i_req && !i_kill && !(own == 1 && done);
            dc = d_req && !(own == 2 && done);
            if (own == 1 && !done && i_kill) begin
                own = 3; age++;
            end else if (!in_t || done) begin
                age = 0;
                if (dc) begin
                    own = 2; m_addr = d_addr; m_we = d_we; m_be = d_be; m_wdata = d_wdata;
                end else if (ic) begin
                    own = 1; m_addr = i_addr; m_we = 0; m_be = 4'hF;
                end else begin
                    own = 0;
                end
            end else begin
                age++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
